// File: rtl/star_pkg.sv
// Shared definitions for the STAR softmax responder: default sizes,
// the weighted-sum FSM state type and one-hot index helpers.
package star_pkg;

    // Default number of CAM/LUT entries held by the responder.
    localparam int STAR_CAM_len   = 16;
    // Length of an input row processed by the STAR engine.
    localparam int STAR_Input_len = 8;
    // Width of a CAM value (x_i and differences are 8-bit).
    localparam int STAR_VAL_W     = 8;
    // Widest match vector the index helpers accept.
    localparam int STAR_IDX_VEC_W = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUM  = 2'd1,
        S_DONE = 2'd2
    } sum_state_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [5:0] onehot_lo_idx(input logic [STAR_IDX_VEC_W-1:0] vec);
        logic [5:0] idx;
        idx = '0;
        for (int k = STAR_IDX_VEC_W - 1; k >= 0; k--) begin
            if (vec[k]) idx = 6'(k);
        end
        return idx;
    endfunction

    // Index of the highest set bit; 0 when the vector is empty.
    function automatic logic [5:0] onehot_hi_idx(input logic [STAR_IDX_VEC_W-1:0] vec);
        logic [5:0] idx;
        idx = '0;
        for (int k = 0; k < STAR_IDX_VEC_W; k++) begin
            if (vec[k]) idx = 6'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/star_cam_match.sv
// Parallel CAM compare: every valid entry whose value equals the key
// raises its bit in the match vector.
module star_cam_match
    import star_pkg::*;
#(
    parameter int CAM_LEN = STAR_CAM_len
) (
    input  logic [CAM_LEN-1:0][STAR_VAL_W-1:0] i_val,
    input  logic [CAM_LEN-1:0]                 i_vld,
    input  logic [STAR_VAL_W-1:0]              i_key,
    output logic [CAM_LEN-1:0]                 o_mv
);

    // Compare all entries against the key in parallel.
    always_comb begin
        o_mv = '0;
        for (int k = 0; k < CAM_LEN; k++) begin
            o_mv[k] = i_vld[k] && (i_val[k] == i_key);
        end
    end

endmodule

// File: rtl/star_cam_responder.sv
// STAR responder: value CAM plus exp LUT answering search, subtract and
// exp queries, and a sequential weighted exp-sum over occurrence counts.
// Index helpers limit CAM_LEN to at most 64 entries.
module star_cam_responder
    import star_pkg::*;
#(
    parameter int CAM_LEN = STAR_CAM_len,
    parameter int AW      = $clog2(CAM_LEN),
    parameter int CNT_W   = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_we,
    input  logic [AW-1:0]            cfg_addr,
    input  logic [7:0]               cfg_val,
    input  logic [31:0]              cfg_exp,
    input  logic                     camsub_req,
    input  logic [7:0]               xi,
    output logic [CAM_LEN-1:0]       xi_mv,
    output logic                     xi_mv_valid,
    output logic                     xi_miss,
    input  logic                     findsub_req,
    input  logic [CAM_LEN-1:0]       xmax_mv,
    input  logic [CAM_LEN-1:0]       xsel_mv,
    output logic [CAM_LEN-1:0]       sub_mv,
    output logic                     sub_mv_valid,
    input  logic                     exp_req,
    input  logic [CAM_LEN-1:0]       exp_sel_mv,
    output logic [31:0]              exp_out,
    output logic                     exp_valid,
    input  logic                     sum_start,
    input  logic [CAM_LEN*CNT_W-1:0] sum_cnt,
    output logic [31:0]              sum_exp,
    output logic                     sum_valid,
    output logic                     busy
);

    logic [CAM_LEN-1:0][STAR_VAL_W-1:0] r_val;
    logic [CAM_LEN-1:0][31:0]           r_lut;
    logic [CAM_LEN-1:0]                 r_vld;

    logic [CAM_LEN-1:0] r_xi_mv;
    logic               r_xi_mv_valid;
    logic               r_xi_miss;
    logic [CAM_LEN-1:0] w_xi_match;

    logic [AW-1:0]           w_imax;
    logic [AW-1:0]           w_isel;
    logic [STAR_VAL_W-1:0]   w_vmax;
    logic [STAR_VAL_W-1:0]   w_vsel;
    logic [STAR_VAL_W-1:0]   w_diff;
    logic [STAR_VAL_W-1:0]   r_d;
    logic                    r_s1_valid;
    logic                    r_s1_empty;
    logic [CAM_LEN-1:0]      w_sub_match;
    logic [CAM_LEN-1:0]      r_sub_mv;
    logic                    r_sub_mv_valid;

    logic [AW-1:0] w_exp_idx;
    logic [31:0]   r_exp_out;
    logic          r_exp_valid;

    sum_state_t               r_state;
    sum_state_t               w_state_next;
    logic [CAM_LEN*CNT_W-1:0] r_cnt;
    logic [AW-1:0]            r_idx;
    logic [31:0]              r_acc;
    logic [31:0]              r_sum_exp;
    logic [CNT_W-1:0]         w_cnt_sel;
    logic [31:0]              w_acc_next;
    logic                     w_last;
    logic                     w_busy;
    logic                     w_sum_valid;

    // CAM/LUT storage; a config write becomes visible after the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_val <= '0;
            r_lut <= '0;
            r_vld <= '0;
        end else if (cfg_we) begin
            r_val[cfg_addr] <= cfg_val;
            r_lut[cfg_addr] <= cfg_exp;
            r_vld[cfg_addr] <= 1'b1;
        end
    end

    star_cam_match #(.CAM_LEN(CAM_LEN)) u_search_match (
        .i_val (r_val),
        .i_vld (r_vld),
        .i_key (xi),
        .o_mv  (w_xi_match)
    );

    // Search response: registered match vector, zero when no request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_xi_mv       <= '0;
            r_xi_mv_valid <= 1'b0;
            r_xi_miss     <= 1'b0;
        end else begin
            r_xi_mv_valid <= camsub_req;
            r_xi_mv       <= camsub_req ? w_xi_match : '0;
            r_xi_miss     <= camsub_req && (w_xi_match == '0);
        end
    end

    assign w_imax = AW'(onehot_hi_idx(STAR_IDX_VEC_W'(xmax_mv)));
    assign w_isel = AW'(onehot_lo_idx(STAR_IDX_VEC_W'(xsel_mv)));
    assign w_vmax = r_val[w_imax];
    assign w_vsel = r_val[w_isel];
    assign w_diff = (w_vmax >= w_vsel) ? (w_vmax - w_vsel) : '0;

    // Subtract stage 1: saturated difference of the max and selected values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_d        <= '0;
            r_s1_valid <= 1'b0;
            r_s1_empty <= 1'b0;
        end else begin
            r_d        <= w_diff;
            r_s1_valid <= findsub_req;
            r_s1_empty <= (xmax_mv == '0) || (xsel_mv == '0);
        end
    end

    star_cam_match #(.CAM_LEN(CAM_LEN)) u_sub_match (
        .i_val (r_val),
        .i_vld (r_vld),
        .i_key (r_d),
        .o_mv  (w_sub_match)
    );

    // Subtract stage 2: look the difference up in the CAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sub_mv       <= '0;
            r_sub_mv_valid <= 1'b0;
        end else begin
            r_sub_mv_valid <= r_s1_valid;
            r_sub_mv       <= (r_s1_valid && !r_s1_empty) ? w_sub_match : '0;
        end
    end

    assign w_exp_idx = AW'(onehot_lo_idx(STAR_IDX_VEC_W'(exp_sel_mv)));

    // Exp lookup: LUT entry of the lowest selected bit, zero for no selection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exp_out   <= '0;
            r_exp_valid <= 1'b0;
        end else begin
            r_exp_valid <= exp_req;
            r_exp_out   <= (exp_req && (exp_sel_mv != '0)) ? r_lut[w_exp_idx] : '0;
        end
    end

    assign w_cnt_sel  = r_cnt[int'(r_idx)*CNT_W +: CNT_W];
    assign w_acc_next = r_acc + (32'(w_cnt_sel) * r_lut[r_idx]);
    assign w_last     = (r_idx == AW'(CAM_LEN - 1));

    // Sum FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Sum FSM next state and status outputs.
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_sum_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sum_start) w_state_next = S_SUM;
            end
            S_SUM: begin
                w_busy = 1'b1;
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                w_sum_valid  = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Sum datapath: one entry per cycle; result held until the next pass ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_acc     <= '0;
            r_sum_exp <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sum_start) begin
                        r_cnt <= sum_cnt;
                        r_idx <= '0;
                        r_acc <= '0;
                    end
                end
                S_SUM: begin
                    r_acc <= w_acc_next;
                    r_idx <= r_idx + 1'b1;
                    if (w_last) r_sum_exp <= w_acc_next;
                end
                default: begin
                end
            endcase
        end
    end

    assign xi_mv        = r_xi_mv;
    assign xi_mv_valid  = r_xi_mv_valid;
    assign xi_miss      = r_xi_miss;
    assign sub_mv       = r_sub_mv;
    assign sub_mv_valid = r_sub_mv_valid;
    assign exp_out      = r_exp_out;
    assign exp_valid    = r_exp_valid;
    assign sum_exp      = r_sum_exp;
    assign sum_valid    = w_sum_valid;
    assign busy         = w_busy;

endmodule

// File: tb/tb_star_cam_responder.sv
// Bench for star_cam_responder: directed steps followed by randomized
// request traffic checked against a behavioural model of the CAM/LUT.
module tb_star_cam_responder;

    localparam int CAM_LEN = 16;
    localparam int AW      = 4;
    localparam int CNT_W   = 3;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     cfg_we;
    logic [AW-1:0]            cfg_addr;
    logic [7:0]               cfg_val;
    logic [31:0]              cfg_exp;
    logic                     camsub_req;
    logic [7:0]               xi;
    logic [CAM_LEN-1:0]       xi_mv;
    logic                     xi_mv_valid;
    logic                     xi_miss;
    logic                     findsub_req;
    logic [CAM_LEN-1:0]       xmax_mv;
    logic [CAM_LEN-1:0]       xsel_mv;
    logic [CAM_LEN-1:0]       sub_mv;
    logic                     sub_mv_valid;
    logic                     exp_req;
    logic [CAM_LEN-1:0]       exp_sel_mv;
    logic [31:0]              exp_out;
    logic                     exp_valid;
    logic                     sum_start;
    logic [CAM_LEN*CNT_W-1:0] sum_cnt;
    logic [31:0]              sum_exp;
    logic                     sum_valid;
    logic                     busy;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [7:0]  mVal [CAM_LEN];
    logic [31:0] mLut [CAM_LEN];
    bit          mVld [CAM_LEN];
    int          mCnt [CAM_LEN];

    logic [15:0] s1Mv, expSubMv, expXiMv, rMax, rSel, rExpSel;
    bit          s1Valid, expSubValid, expMiss, rC, rF, rE;
    logic [31:0] expExp;
    logic [7:0]  rXi;
    int          lat, pulses;

    star_cam_responder dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_val      (cfg_val),
        .cfg_exp      (cfg_exp),
        .camsub_req   (camsub_req),
        .xi           (xi),
        .xi_mv        (xi_mv),
        .xi_mv_valid  (xi_mv_valid),
        .xi_miss      (xi_miss),
        .findsub_req  (findsub_req),
        .xmax_mv      (xmax_mv),
        .xsel_mv      (xsel_mv),
        .sub_mv       (sub_mv),
        .sub_mv_valid (sub_mv_valid),
        .exp_req      (exp_req),
        .exp_sel_mv   (exp_sel_mv),
        .exp_out      (exp_out),
        .exp_valid    (exp_valid),
        .sum_start    (sum_start),
        .sum_cnt      (sum_cnt),
        .sum_exp      (sum_exp),
        .sum_valid    (sum_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Reference model: search returns every valid entry holding the key.
    function automatic logic [15:0] modelSearch(input logic [7:0] key);
        logic [15:0] mv;
        mv = '0;
        for (int k = 0; k < CAM_LEN; k++)
            if (mVld[k] && mVal[k] == key) mv[k] = 1'b1;
        return mv;
    endfunction

    // Reference model: highest bit of xmax minus lowest bit of xsel, floored at 0.
    function automatic logic [15:0] modelSub(input logic [15:0] xmaxV, input logic [15:0] xselV);
        int hi, lo, d;
        if (xmaxV == 0 || xselV == 0) return '0;
        hi = 0;
        lo = 0;
        for (int k = 0; k < CAM_LEN; k++) if (xmaxV[k]) hi = k;
        for (int k = CAM_LEN - 1; k >= 0; k--) if (xselV[k]) lo = k;
        d = int'(mVal[hi]) - int'(mVal[lo]);
        if (d < 0) d = 0;
        return modelSearch(8'(d));
    endfunction

    // Reference model: LUT value of the first selected entry.
    function automatic logic [31:0] modelExp(input logic [15:0] sel);
        for (int k = 0; k < CAM_LEN; k++) if (sel[k]) return mLut[k];
        return '0;
    endfunction

    // Reference model: weighted sum, modulo 2^32.
    function automatic logic [31:0] modelSum();
        logic [63:0] s;
        s = '0;
        for (int k = 0; k < CAM_LEN; k++) s += 64'(mCnt[k]) * 64'(mLut[k]);
        return s[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit cReq, input logic [7:0] xiV, input bit fReq,
                                 input logic [15:0] maxV, input logic [15:0] selV,
                                 input bit eReq, input logic [15:0] eSel);
        camsub_req  = cReq;
        xi          = xiV;
        findsub_req = fReq;
        xmax_mv     = maxV;
        xsel_mv     = selV;
        exp_req     = eReq;
        exp_sel_mv  = eSel;
    endtask

    task automatic loadEntry(input int k, input logic [7:0] v, input logic [31:0] e);
        cfg_we   = 1'b1;
        cfg_addr = AW'(k);
        cfg_val  = v;
        cfg_exp  = e;
        tick();
        cfg_we   = 1'b0;
        mVal[k]  = v;
        mLut[k]  = e;
        mVld[k]  = 1'b1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < CAM_LEN; k++) begin
            mVal[k] = '0;
            mLut[k] = '0;
            mVld[k] = 1'b0;
        end
    endtask

    task automatic packCounts();
        for (int k = 0; k < CAM_LEN; k++) sum_cnt[k*CNT_W +: CNT_W] = CNT_W'(mCnt[k]);
    endtask

    initial begin
        reset     = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_val   = '0;
        cfg_exp   = '0;
        sum_start = 1'b0;
        sum_cnt   = '0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        doReset();

        checkOutput("rst_xi_mv", 32'(xi_mv), 0);
        checkOutput("rst_xi_valid", 32'(xi_mv_valid), 0);
        checkOutput("rst_xi_miss", 32'(xi_miss), 0);
        checkOutput("rst_sub_valid", 32'(sub_mv_valid), 0);
        checkOutput("rst_exp_valid", 32'(exp_valid), 0);
        checkOutput("rst_sum_valid", 32'(sum_valid), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_sum_exp", sum_exp, 0);

        for (int k = 0; k < CAM_LEN; k++) loadEntry(k, 8'(4*k), 32'(1) << k);

        applyStimulus(1, 12, 0, 0, 0, 0, 0);
        tick();
        checkOutput("srch12_mv", 32'(xi_mv), 32'h0008);
        checkOutput("srch12_valid", 32'(xi_mv_valid), 1);
        checkOutput("srch12_miss", 32'(xi_miss), 0);
        applyStimulus(1, 13, 0, 0, 0, 0, 0);
        tick();
        checkOutput("srch13_mv", 32'(xi_mv), 0);
        checkOutput("srch13_miss", 32'(xi_miss), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("idle_xi_valid", 32'(xi_mv_valid), 0);
        checkOutput("idle_xi_miss", 32'(xi_miss), 0);

        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("b2b_0", 32'(xi_mv), 32'h0001);
        applyStimulus(1, 4, 0, 0, 0, 0, 0);
        tick();
        checkOutput("b2b_4", 32'(xi_mv), 32'h0002);
        applyStimulus(1, 8, 0, 0, 0, 0, 0);
        tick();
        checkOutput("b2b_8", 32'(xi_mv), 32'h0004);

        applyStimulus(0, 0, 1, 16'h0041, 16'h0004, 0, 0);
        tick();
        applyStimulus(0, 0, 1, 16'h0004, 16'h0040, 0, 0);
        checkOutput("sub_lat1_valid", 32'(sub_mv_valid), 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("sub_pos_mv", 32'(sub_mv), 32'h0010);
        checkOutput("sub_pos_valid", 32'(sub_mv_valid), 1);
        tick();
        checkOutput("sub_neg_mv", 32'(sub_mv), 32'h0001);
        applyStimulus(0, 0, 1, 16'h0000, 16'h0004, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("sub_empty_mv", 32'(sub_mv), 0);
        checkOutput("sub_empty_valid", 32'(sub_mv_valid), 1);

        applyStimulus(0, 0, 0, 0, 0, 1, 16'h0020);
        tick();
        checkOutput("exp_sel5", exp_out, 32);
        checkOutput("exp_sel5_valid", 32'(exp_valid), 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 16'h0000);
        tick();
        checkOutput("exp_sel0", exp_out, 0);
        checkOutput("exp_sel0_valid", 32'(exp_valid), 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 16'h0030);
        tick();
        checkOutput("exp_multi", exp_out, 16);

        applyStimulus(1, 20, 1, 16'h0100, 16'h0002, 1, 16'h8000);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("simul_xi", 32'(xi_mv), 32'h0020);
        checkOutput("simul_exp", exp_out, 32'h8000);
        tick();
        checkOutput("simul_sub", 32'(sub_mv), 32'h0080);

        cfg_we   = 1'b1;
        cfg_addr = 4'd3;
        cfg_val  = 8'd99;
        cfg_exp  = 32'h8;
        applyStimulus(1, 99, 0, 0, 0, 0, 0);
        tick();
        cfg_we  = 1'b0;
        mVal[3] = 8'd99;
        checkOutput("wr_same_cycle_miss", 32'(xi_miss), 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("wr_after_hit", 32'(xi_mv), 32'h0008);

        for (int k = 0; k < CAM_LEN; k++) mCnt[k] = 0;
        mCnt[0] = 3;
        mCnt[4] = 2;
        packCounts();
        sum_start = 1'b1;
        tick();
        sum_start = 1'b0;
        checkOutput("sum_busy", 32'(busy), 1);
        lat = 1;
        while (sum_valid !== 1'b1 && lat < 40) begin
            sum_start = (lat == 3);
            if (lat == 3) sum_cnt = '1;
            tick();
            lat++;
        end
        sum_start = 1'b0;
        checkOutput("sum_latency", 32'(lat), 17);
        checkOutput("sum_value", sum_exp, 35);
        checkOutput("sum_done_busy", 32'(busy), 0);
        tick();
        checkOutput("sum_pulse_len", 32'(sum_valid), 0);
        checkOutput("sum_hold", sum_exp, 35);
        checkOutput("sum_no_restart", 32'(busy), 0);

        doReset();
        for (int k = 0; k < CAM_LEN; k++)
            if ($urandom_range(0, 3) != 0) loadEntry(k, 8'($urandom_range(0, 31)), $urandom);

        s1Valid = 1'b0;
        s1Mv    = '0;
        for (int n = 0; n < 300; n++) begin
            rC  = 1'($urandom_range(0, 1));
            rF  = 1'($urandom_range(0, 1));
            rE  = 1'($urandom_range(0, 1));
            rXi = 8'($urandom_range(0, 31));
            rMax    = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            rSel    = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            rExpSel = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            expXiMv     = rC ? modelSearch(rXi) : '0;
            expMiss     = rC && (expXiMv == 0);
            expExp      = modelExp(rExpSel);
            expSubMv    = s1Mv;
            expSubValid = s1Valid;
            s1Mv        = rF ? modelSub(rMax, rSel) : '0;
            s1Valid     = rF;
            applyStimulus(rC, rXi, rF, rMax, rSel, rE, rExpSel);
            tick();
            checkOutput("rnd_xi_mv", 32'(xi_mv), 32'(expXiMv));
            checkOutput("rnd_xi_valid", 32'(xi_mv_valid), 32'(rC));
            checkOutput("rnd_xi_miss", 32'(xi_miss), 32'(expMiss));
            checkOutput("rnd_sub_valid", 32'(sub_mv_valid), 32'(expSubValid));
            if (expSubValid) checkOutput("rnd_sub_mv", 32'(sub_mv), 32'(expSubMv));
            checkOutput("rnd_exp_valid", 32'(exp_valid), 32'(rE));
            if (rE) checkOutput("rnd_exp_out", exp_out, expExp);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < CAM_LEN; k++) mCnt[k] = $urandom_range(0, 7);
            packCounts();
            sum_start = 1'b1;
            tick();
            sum_start = 1'b0;
            lat = 1;
            while (sum_valid !== 1'b1 && lat < 40) begin
                tick();
                lat++;
            end
            checkOutput("rnd_sum_latency", 32'(lat), 17);
            checkOutput("rnd_sum_value", sum_exp, modelSum());
            tick();
        end

        for (int k = 0; k < CAM_LEN; k++) mCnt[k] = 1;
        packCounts();
        sum_start = 1'b1;
        tick();
        sum_start = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        reset = 1'b1;
        tick();
        checkOutput("midrst_busy", 32'(busy), 0);
        checkOutput("midrst_valid", 32'(sum_valid), 0);
        reset = 1'b0;
        for (int k = 0; k < CAM_LEN; k++) mVld[k] = 1'b0;
        pulses = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (sum_valid === 1'b1) pulses++;
        end
        checkOutput("midrst_no_pulse", 32'(pulses), 0);
        checkOutput("midrst_idle_busy", 32'(busy), 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("midrst_xi0_miss", 32'(xi_miss), 1);
        checkOutput("midrst_xi0_mv", 32'(xi_mv), 32'(modelSearch(8'd0)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
